// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcodes, funct codes and the multiply sequencer state type.
package dlx_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_R        = 6'h00;
    localparam logic [5:0] OP_MULT     = 6'h01;

    // R-type funct codes for the multiply family
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

    // Multiply sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_step.sv
// One iteration of the shift-add multiplier: adds the multiplicand, shifted to
// match each of the BPC low multiplier bits, then advances both operands by BPC.
// Ports:
//   acc, mcand, mplier          current accumulator / multiplicand / multiplier
//   acc_nxt, mcand_nxt, mplier_nxt  values after retiring BPC multiplier bits
module mult_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [2*WIDTH-1:0] mcand_nxt,
    output logic [WIDTH-1:0]   mplier_nxt
);

    // Partial-product accumulation, modulo 2^(2*WIDTH)
    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < int'(BPC); i++) begin
            if (mplier[i]) begin
                acc_nxt = acc_nxt + (mcand << i);
            end
        end
    end

    assign mcand_nxt  = mcand << BPC;
    assign mplier_nxt = mplier >> BPC;

endmodule

// File: rtl/mult_sequencer.sv
// Iterative shift-add multiply unit and sequencer for the DLX EX stage.
// Accepts one multiply from EX, stalls IF/ID/EX while it iterates, then
// presents a 2*WIDTH-bit product and its destination register for write-back.
// Optional build macro MULT_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all zero (same result, shorter latency).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           multiply in EX (sampled in IDLE only)
//   signed_i          1 = MULT (signed), 0 = MULTU
//   op_a_i, op_b_i    multiplicand, multiplier
//   dest_i            destination register
//   abort_i           flush of the in-flight multiply
//   stall_o           hold IF/ID/EX (combinational)
//   busy_o            sequencer not idle
//   done_o            one-cycle result-valid pulse
//   result_hi_o/lo_o  product halves, held until the next completion
//   wb_reg_o          destination tag accompanying done_o
import dlx_pkg::*;

module mult_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic [4:0]       dest_i,
    input  logic             abort_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic [WIDTH-1:0] result_lo_o,
    output logic [4:0]       wb_reg_o
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned STEPS = WIDTH / BPC;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    mult_state_t     state, state_nxt;
    logic [PW-1:0]   acc, mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   count;
    logic            neg;
    logic [4:0]      dest;

    logic [PW-1:0]    acc_nxt, mcand_nxt;
    logic [WIDTH-1:0] mplier_nxt;
    logic [PW-1:0]    acc_fix;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             load, step_en, finish, early_zero;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned
    assign a_mag = (signed_i && op_a_i[WIDTH-1]) ? (~op_a_i + WIDTH'(1)) : op_a_i;
    assign b_mag = (signed_i && op_b_i[WIDTH-1]) ? (~op_b_i + WIDTH'(1)) : op_b_i;

    assign acc_fix = neg ? (~acc + PW'(1)) : acc;

    mult_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

`ifdef MULT_EARLY_TERM_EN
    // Nothing left to add once the shifted-out multiplier is empty
    assign early_zero = (mplier_nxt == '0);
`else
    assign early_zero = 1'b0;
`endif

    // Combinational so the instruction behind the multiply never advances
    assign stall_o = (start_i && (state == IDLE) && !abort_i) || (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step_en   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !abort_i) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_nxt = IDLE;
                end else begin
                    step_en = 1'b1;
                    if ((count == CW'(1)) || early_zero) begin
                        state_nxt = FIX;
                    end
                end
            end
            FIX: begin
                state_nxt = IDLE;
                finish    = !abort_i;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand, accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            count       <= '0;
            neg         <= 1'b0;
            dest        <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            result_hi_o <= '0;
            result_lo_o <= '0;
            wb_reg_o    <= '0;
        end else begin
            busy_o <= (state_nxt != IDLE);
            done_o <= finish;
            if (load) begin
                acc    <= '0;
                mcand  <= {WIDTH'(0), a_mag};
                mplier <= b_mag;
                count  <= CW'(STEPS);
                neg    <= signed_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
                dest   <= dest_i;
            end else if (step_en) begin
                acc    <= acc_nxt;
                mcand  <= mcand_nxt;
                mplier <= mplier_nxt;
                count  <= count - CW'(1);
            end
            if (finish) begin
                result_hi_o <= acc_fix[PW-1:WIDTH];
                result_lo_o <= acc_fix[WIDTH-1:0];
                wb_reg_o    <= dest;
            end
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed table, hand-written
// abort/reset/back-to-back sequences and randomized operands against a
// plain-arithmetic product model.
module tb_mult_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned BPC   = 1;
`ifdef MULT_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i, signed_i, abort_i;
    logic [WIDTH-1:0] op_a_i, op_b_i;
    logic [4:0]       dest_i;
    logic             stall_o, busy_o, done_o;
    logic [WIDTH-1:0] result_hi_o, result_lo_o;
    logic [4:0]       wb_reg_o;

    int errors = 0;
    int checks = 0;

    mult_sequencer #(.WIDTH(WIDTH), .BPC(BPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .dest_i      (dest_i),
        .abort_i     (abort_i),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_hi_o (result_hi_o),
        .result_lo_o (result_lo_o),
        .wb_reg_o    (wb_reg_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Starting a multiply while the pipeline is stalled is illegal
    always @(posedge clk) begin
        if (rst_n === 1'b1 && busy_o === 1'b1 && start_i === 1'b1) begin
            errors++;
            $display("FAIL illegal_start: start_i=1 while busy_o=1");
        end
    end

    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic int early_lat(input bit s, input logic [31:0] b);
        logic [31:0] m;
        int top;
        int it;
        m = (s && b[31]) ? (~b + 32'd1) : b;
        top = 0;
        for (int i = 0; i < 32; i++) if (m[i]) top = i + 1;
        it = (top + int'(BPC) - 1) / int'(BPC);
        if (it < 1) it = 1;
        return it + 1;
    endfunction

    function automatic int exp_lat(input bit s, input logic [31:0] b);
        return ET ? early_lat(s, b) : int'(WIDTH / BPC) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a multiply in the current cycle and let the edge accept it
    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        start_i  = 1'b1;
        signed_i = s;
        op_a_i   = a;
        op_b_i   = b;
        dest_i   = d;
        #1;
        chk("stall_on_start", 64'(stall_o), 64'd1);
        tick();
        start_i = 1'b0;
        op_a_i  = $urandom;
        op_b_i  = $urandom;
    endtask

    // Count edges until done_o, bounded; checks stall/busy on the way
    task automatic wait_done(output int lat, output int busy_n, output bit stall_ok);
        lat = 0;
        busy_n = 0;
        stall_ok = 1'b1;
        while (done_o !== 1'b1 && lat < 100) begin
            if (stall_o !== 1'b1) stall_ok = 1'b0;
            if (busy_o === 1'b1) busy_n++;
            tick();
            lat++;
        end
    endtask

    task automatic run_check(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] d, input logic [63:0] exp);
        int lat, busy_n;
        bit stall_ok;
        issue(s, a, b, d);
        wait_done(lat, busy_n, stall_ok);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(s, b)));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat(s, b)));
        chk({tag, "_stall_held"}, 64'(stall_ok), 64'd1);
        chk({tag, "_product"}, {result_hi_o, result_lo_o}, exp);
        chk({tag, "_wb_reg"}, 64'(wb_reg_o), 64'(d));
        chk({tag, "_stall_in_done"}, 64'(stall_o), 64'd0);
    endtask

    initial begin
        int lat, busy_n;
        bit stall_ok, flag;
        logic [31:0] ra, rb;
        logic [63:0] prev;
        logic [4:0] prev_wb;
        bit rs;

        tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 32'h00000001};
        tbl[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 5'd1,  32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[2] = '{1'b1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 32'h00000000};
        tbl[3] = '{1'b0, 32'h00001234, 32'h00000003, 5'd3,  32'h00000000, 32'h0000369C};
        tbl[4] = '{1'b1, 32'h80000000, 32'h00000001, 5'd4,  32'hFFFFFFFF, 32'h80000000};
        tbl[5] = '{1'b0, 32'h80000000, 32'h00000002, 5'd6,  32'h00000001, 32'h00000000};
        tbl[6] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 5'd7,  32'h00000000, 32'h00000000};
        tbl[7] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'h00000000, 32'h00000001};
        tbl[8] = '{1'b0, 32'h12345678, 32'h00000000, 5'd9,  32'h00000000, 32'h00000000};

        rst_n = 1'b0; start_i = 1'b0; signed_i = 1'b0; abort_i = 1'b0;
        op_a_i = '0; op_b_i = '0; dest_i = '0;
        #12;
        chk("reset_outputs", {27'd0, stall_o, busy_o, done_o, wb_reg_o}, 64'd0);
        chk("reset_result", {result_hi_o, result_lo_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].dest,
                      {tbl[i].hi, tbl[i].lo});
            tick();
            chk($sformatf("vec%0d_done_one_cycle", i), 64'(done_o), 64'd0);
        end

        // start and abort together in IDLE: nothing accepted
        prev = {result_hi_o, result_lo_o};
        start_i = 1'b1; abort_i = 1'b1; signed_i = 1'b0;
        op_a_i = 32'd5; op_b_i = 32'd5; dest_i = 5'd12;
        #1;
        chk("start_abort_stall", 64'(stall_o), 64'd0);
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        chk("start_abort_busy", 64'(busy_o), 64'd0);
        tick();
        chk("start_abort_no_done", 64'(done_o), 64'd0);

        // Abort at RUN cycle 10; previous result must survive
        prev = {result_hi_o, result_lo_o};
        prev_wb = wb_reg_o;
        issue(1'b0, 32'hDEADBEEF, 32'h12345678, 5'd20);
        repeat (9) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_no_done", 64'(done_o), 64'd0);
        chk("abort_result_kept", {result_hi_o, result_lo_o}, prev);
        chk("abort_wb_kept", 64'(wb_reg_o), 64'(prev_wb));
        tick();
        run_check("after_abort", 1'b0, 32'h0000FFFF, 32'h00010001, 5'd11, 64'h00000000FFFFFFFF);

        // Back-to-back: second start in the done cycle
        issue(1'b1, 32'hFFFFFFF0, 32'h00000010, 5'd13);
        wait_done(lat, busy_n, stall_ok);
        chk("b2b_first_lat", 64'(lat), 64'(exp_lat(1'b1, 32'h00000010)));
        chk("b2b_first_product", {result_hi_o, result_lo_o}, 64'hFFFFFFFFFFFFFF00);
        chk("b2b_first_wb", 64'(wb_reg_o), 64'd13);
        run_check("b2b_second", 1'b0, 32'h00010000, 32'h00010000, 5'd14, 64'h0000000100000000);

        // Reset at RUN cycle 20; no completion afterwards
        issue(1'b0, 32'hCAFEF00D, 32'h87654321, 5'd21);
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {27'd0, stall_o, busy_o, done_o, wb_reg_o}, 64'd0);
        chk("midreset_result", {result_hi_o, result_lo_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done_o !== 1'b0 || busy_o !== 1'b0) flag = 1'b1;
        end
        chk("midreset_quiet_40", 64'(flag), 64'd0);

        // Randomized operands against the arithmetic model
        for (int n = 0; n < 24; n++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                2: ra = 32'($urandom_range(0, 255));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'h80000000;
                1: rb = 32'd0;
                2: rb = 32'($urandom_range(0, 1023));
                default: rb = $urandom;
            endcase
            run_check($sformatf("rand%0d", n), rs, ra, rb, 5'($urandom_range(0, 31)), model(rs, ra, rb));
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
